decode_stage: RTL and testbench

//  Instruction decode / register-read stage; producer of the ALU operand interface.

---
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decode / register-read stage feeding the ALU.
// A 32-bit MIPS-style word is split into type/opcode/imm/target/rd. Rs1 and
// Rs2 are read from an internal 32-entry register file. All ALU-facing fields
// sit in one output register that uses a valid/ready handshake.
// The optional macro WB_BYPASS_EN forwards same-cycle writeback data into the
// operands when an instruction is accepted. Without it, an accept reads the
// register value from before the write.
module decode_stage #(
  parameter int DATA_W         = 32,
  parameter int RF_RESET_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        type_inst,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] Rs1_val,
  output logic [DATA_W-1:0] Rs2_val,
  output logic [15:0]       imm,
  output logic [25:0]       target,
  output logic [4:0]        rd
);

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_R    = 2'b01;
  localparam logic [1:0] TYPE_I    = 2'b10;
  localparam logic [1:0] TYPE_J    = 2'b11;

  // Register file. Entry 0 is never written, and reads of index 0 are forced to zero.
  logic [DATA_W-1:0] rf_mem [32];

  // Output register state
  logic              out_valid_reg;
  logic [1:0]        type_reg;
  logic [5:0]        opcode_reg;
  logic [DATA_W-1:0] rs1_val_reg;
  logic [DATA_W-1:0] rs2_val_reg;
  logic [15:0]       imm_reg;
  logic [25:0]       target_reg;
  logic [4:0]        rd_reg;
  // Source indices of the held instruction, kept for operand refresh during a stall
  logic [4:0]        rs1_idx_reg;
  logic [4:0]        rs2_idx_reg;

  // Instruction field slices
  logic [5:0] op_field;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  // Decoder results
  logic [1:0]        dec_type;
  logic [5:0]        dec_opcode;
  logic [25:0]       dec_target;
  logic [4:0]        dec_rd;
  logic [DATA_W-1:0] rs1_rd;
  logic [DATA_W-1:0] rs2_rd;

  logic accept;
  logic stall;

  assign op_field = instr[31:26];
  assign rs1_idx  = instr[25:21];
  assign rs2_idx  = instr[20:16];

  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign stall    = out_valid_reg & ~out_ready;

  // Classify the instruction and derive the per-type fields.
  always_comb begin
    dec_type   = TYPE_NONE;
    dec_opcode = op_field;
    dec_target = '0;
    dec_rd     = '0;
    if (op_field == 6'h00) begin
      dec_type   = TYPE_R;
      dec_opcode = instr[5:0];
      dec_rd     = instr[15:11];
    end else if (op_field == 6'h02 || op_field == 6'h03) begin
      dec_type   = TYPE_J;
      dec_target = instr[25:0];
      dec_rd     = (op_field == 6'h03) ? 5'd31 : 5'd0;
    end else if (op_field <= 6'h2B) begin
      // Opcodes 0x01 and 0x04-0x2B; 0x00 and 0x02/0x03 were handled above
      dec_type = TYPE_I;
      dec_rd   = instr[20:16];
    end
  end

  // Operand read. With the bypass enabled, a same-cycle writeback to the same
  // register is forwarded; otherwise the pre-write value is taken.
  always_comb begin
    rs1_rd = (rs1_idx == 5'd0) ? '0 : rf_mem[rs1_idx];
    rs2_rd = (rs2_idx == 5'd0) ? '0 : rf_mem[rs2_idx];
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs1_idx) rs1_rd = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs2_idx) rs2_rd = wb_data;
`endif
  end

  // Register file write port. Reset may clear all entries.
  always_ff @(posedge clk) begin
    if (reset && (RF_RESET_CLEAR != 0)) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_mem[wb_addr] <= wb_data;
    end
  end

  // Output register: reset and flush clear it, accept loads it, a stall holds
  // it but refreshes matching operands, and a transfer without a new accept
  // drops valid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_reg <= 1'b0;
      type_reg      <= TYPE_NONE;
      opcode_reg    <= '0;
      rs1_val_reg   <= '0;
      rs2_val_reg   <= '0;
      imm_reg       <= '0;
      target_reg    <= '0;
      rd_reg        <= '0;
      rs1_idx_reg   <= '0;
      rs2_idx_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      type_reg      <= dec_type;
      opcode_reg    <= dec_opcode;
      rs1_val_reg   <= rs1_rd;
      rs2_val_reg   <= rs2_rd;
      imm_reg       <= instr[15:0];
      target_reg    <= dec_target;
      rd_reg        <= dec_rd;
      rs1_idx_reg   <= rs1_idx;
      rs2_idx_reg   <= rs2_idx;
    end else if (stall) begin
      if (wb_en && wb_addr != 5'd0 && wb_addr == rs1_idx_reg) rs1_val_reg <= wb_data;
      if (wb_en && wb_addr != 5'd0 && wb_addr == rs2_idx_reg) rs2_val_reg <= wb_data;
    end else if (out_valid_reg) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign type_inst = type_reg;
  assign opcode    = opcode_reg;
  assign Rs1_val   = rs1_val_reg;
  assign Rs2_val   = rs2_val_reg;
  assign imm       = imm_reg;
  assign target    = target_reg;
  assign rd        = rd_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// A reference model runs on each rising edge. On every accept it pushes the
// expected output entry into a queue. A separate monitor runs on the falling
// edge and compares the DUT outputs with the head of that queue.
// The bench follows WB_BYPASS_EN in the same way as the RTL.
module tb_decode_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    type_inst;
  logic [5:0]    opcode;
  logic [DW-1:0] Rs1_val;
  logic [DW-1:0] Rs2_val;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic [4:0]    rd;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(DW), .RF_RESET_CLEAR(1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .type_inst(type_inst), .opcode(opcode), .Rs1_val(Rs1_val),
    .Rs2_val(Rs2_val), .imm(imm), .target(target), .rd(rd)
  );

  typedef struct packed {
    logic [1:0]  ty;
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
    logic [25:0] tgt;
    logic [4:0]  rdst;
    logic [4:0]  s1;
    logic [4:0]  s2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf_m [32];
  bit          exp_valid = 1'b0;
  int          idle_state = 0;   // 0: none, 1: all outputs zero, 2: type_inst zero
  int          total = 0;
  int          bad = 0;
  int          n_xfer = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Decode directly from the opcode table.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   op;
    op = int'(w[31:26]);
    e = '0;
    if (op == 0) e.ty = 2'b01;
    else if (op == 2 || op == 3) e.ty = 2'b11;
    else if (op >= 1 && op <= 43) e.ty = 2'b10;
    else e.ty = 2'b00;
    e.opc  = (e.ty == 2'b01) ? w[5:0] : w[31:26];
    e.im   = w[15:0];
    e.tgt  = (e.ty == 2'b11) ? w[25:0] : 26'd0;
    case (e.ty)
      2'b01:   e.rdst = w[15:11];
      2'b10:   e.rdst = w[20:16];
      2'b11:   e.rdst = (op == 3) ? 5'd31 : 5'd0;
      default: e.rdst = 5'd0;
    endcase
    e.s1 = w[25:21];
    e.s2 = w[20:16];
    return e;
  endfunction

  // Register value as seen by an instruction accepted this cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == s) return wb_data;
`endif
    return rf_m[s];
  endfunction

  // Reference model: updates state once per rising edge.
  initial begin
    exp_t e;
    bit   rdy;
    bit   acc;
    bit   stl;
    forever begin
      @(posedge clk);
      if (reset) begin
        sb_q.delete();
        exp_valid  = 1'b0;
        idle_state = 1;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
      end else begin
        rdy = !exp_valid || out_ready;
        acc = in_valid && rdy && !flush;
        stl = exp_valid && !out_ready;
        if (flush) begin
          sb_q.delete();
          exp_valid  = 1'b0;
          idle_state = 2;
        end else if (acc) begin
          e   = ref_decode(instr);
          e.a = ref_read(e.s1);
          e.b = ref_read(e.s2);
          sb_q.push_back(e);
          exp_valid  = 1'b1;
          idle_state = 0;
        end else if (stl) begin
          if (sb_q.size() > 0 && wb_en && wb_addr != 5'd0) begin
            if (wb_addr == sb_q[0].s1) sb_q[0].a = wb_data;
            if (wb_addr == sb_q[0].s2) sb_q[0].b = wb_data;
          end
        end else if (exp_valid) begin
          exp_valid = 1'b0;
        end
        if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
      end
    end
  end

  // Monitor: compares the DUT outputs with the scoreboard on each falling edge.
  initial begin
    exp_t f;
    forever begin
      @(negedge clk);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_valid || out_ready)});
      if (exp_valid) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          f = sb_q[0];
          chk("type_inst", {30'd0, type_inst}, {30'd0, f.ty});
          chk("opcode", {26'd0, opcode}, {26'd0, f.opc});
          chk("Rs1_val", Rs1_val, f.a);
          chk("Rs2_val", Rs2_val, f.b);
          chk("imm", {16'd0, imm}, {16'd0, f.im});
          chk("target", {6'd0, target}, {6'd0, f.tgt});
          chk("rd", {27'd0, rd}, {27'd0, f.rdst});
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_xfer++;
            $display("xfer %0d: type=%0d opcode=%h rs1=%h rs2=%h imm=%h rd=%0d",
                     n_xfer, type_inst, opcode, Rs1_val, Rs2_val, imm, rd);
          end
        end
      end else if (idle_state == 1) begin
        chk("rst_type", {30'd0, type_inst}, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        chk("rst_Rs1", Rs1_val, 32'd0);
        chk("rst_Rs2", Rs2_val, 32'd0);
        chk("rst_imm", {16'd0, imm}, 32'd0);
        chk("rst_target", {6'd0, target}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
      end else if (idle_state == 2) begin
        chk("flush_type", {30'd0, type_inst}, 32'd0);
      end
    end
  end

  // Apply one cycle of inputs, then wait until just after the next rising edge.
  task automatic step(input logic iv, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rst);
    in_valid  = iv;
    instr     = w;
    out_ready = ordy;
    flush     = fl;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    logic [31:0] w;
    int          pick;
    reset = 1'b1; instr = '0; in_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 1, 0, 0, 0, 0, 1);
    // Write r1=3 and r2=4, then issue one R instruction.
    step(0, 0, 1, 0, 1, 5'd1, 32'd3, 0);
    step(0, 0, 1, 0, 1, 5'd2, 32'd4, 0);
    step(1, 32'h00221820, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Stall for three cycles while another instruction is offered.
    step(1, 32'h0022182A, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h2024FFFC, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // I-type instruction.
    step(1, 32'h2024FFFC, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Writeback to r2 in the same cycle as an accept.
    step(1, 32'h00221820, 1, 0, 1, 5'd2, 32'hFFFFFFFC, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Refresh a held operand while stalled; a write to r0 is ignored.
    step(1, 32'h00221820, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd1, 32'd7, 0);
    step(0, 0, 0, 0, 1, 5'd0, 32'd9, 0);
    step(1, 32'h00001020, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Flush while stalled with an instruction offered.
    step(1, 32'h00221820, 0, 0, 0, 0, 0, 0);
    step(1, 32'h2024FFFC, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Reset in the middle of a stall, and reset together with flush.
    step(1, 32'h0C000123, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h08000055, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Randomized traffic with a small register set to create hazards.
    for (int n = 0; n < 3000; n++) begin
      w    = $urandom;
      pick = int'($urandom_range(0, 7));
      case (pick)
        0:       w[31:26] = 6'h00;
        1:       w[31:26] = 6'h02;
        2:       w[31:26] = 6'h03;
        3, 4, 5: w[31:26] = 6'($urandom_range(1, 43));
        6:       w[31:26] = 6'($urandom_range(44, 63));
        default: w[31:26] = 6'($urandom_range(0, 63));
      endcase
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      step(($urandom % 4) != 0, w, ($urandom % 3) != 0, ($urandom % 16) == 0,
           ($urandom % 2) == 0, 5'($urandom_range(0, 3)), $urandom,
           ($urandom % 250) == 0);
    end
    // Drain the pipeline; the scoreboard must end up empty.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
